// File: rtl/usb_tx_pkg.sv
// Shared constants and types for the USB transmit path.
// State enum, SYNC pattern, CRC16 constants and field lengths.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'b1000_0000;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [2:0]  STUFF_LIMIT  = 3'd6;

  localparam int SYNC_LEN = 8;
  localparam int PID_LEN  = 8;
  localparam int DATA_LEN = 64;
  localparam int CRC_LEN  = 16;
  localparam int EOP_LEN  = 3;

endpackage

// File: rtl/send_data_crc16_gen.sv
// Serial CRC16 LFSR (x^16+x^15+x^2+1), one bit per enabled clock.
// Ports: clk, rst_L, clear (load init), shift_en, bit_in, crc.
module crc16_gen
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ bit_in;

  always_ff @(posedge clk) begin
    if (!rst_L || clear) begin
      crc <= CRC16_INIT;
    end else if (shift_en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/send_data.sv
// USB transmit packet sequencer: SYNC, PID, DATA, CRC16, EOP as NRZ bits.
// Ports: clk, rst_L, send_start/has_data/pid/data in; tx_bit/tx_se0/tx_active/busy/done out.
module send_data
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic        send_start,
  input  logic        has_data,
  input  logic [3:0]  pid,
  input  logic [63:0] data,
  output logic        tx_bit,
  output logic        tx_se0,
  output logic        tx_active,
  output logic        busy,
  output logic        done
);

  tx_state_t   state, state_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  ones_cnt, ones_cnt_n;
  logic [3:0]  pid_q;
  logic [63:0] data_q;
  logic        has_data_q;
  logic [15:0] crc;
  logic        stuff;
  logic        start_ok;
  logic        crc_shift;

  assign start_ok  = (state == ST_IDLE) && send_start;
  assign stuff     = ((state == ST_DATA) || (state == ST_CRC))
                     && (ones_cnt == STUFF_LIMIT);
  assign crc_shift = (state == ST_DATA) && !stuff;
  assign tx_active = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);

  crc16_gen u_crc (
    .clk      (clk),
    .rst_L    (rst_L),
    .clear    (start_ok),
    .shift_en (crc_shift),
    .bit_in   (tx_bit),
    .crc      (crc)
  );

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      pid_q      <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      ones_cnt <= ones_cnt_n;
      if (start_ok) begin
        pid_q      <= pid;
        data_q     <= data;
        has_data_q <= has_data;
      end
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    ones_cnt_n = ones_cnt;
    tx_bit     = 1'b1;
    tx_se0     = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (send_start) begin
          state_n    = ST_SYNC;
          bit_cnt_n  = '0;
          ones_cnt_n = '0;
        end
      end
      ST_SYNC: begin
        tx_bit = SYNC_PATTERN[bit_cnt[2:0]];
        if (bit_cnt == 6'(SYNC_LEN - 1)) begin
          state_n   = ST_PID;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
      ST_PID: begin
        tx_bit = bit_cnt[2] ? ~pid_q[bit_cnt[1:0]]
                            : pid_q[bit_cnt[1:0]];
        if (bit_cnt == 6'(PID_LEN - 1)) begin
          state_n    = has_data_q ? ST_DATA : ST_EOP;
          bit_cnt_n  = '0;
          ones_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
      ST_DATA: begin
        if (stuff) begin
          tx_bit     = 1'b0;
          ones_cnt_n = '0;
        end else begin
          tx_bit     = data_q[bit_cnt];
          ones_cnt_n = tx_bit ? ones_cnt + 3'd1 : 3'd0;
          if (bit_cnt == 6'(DATA_LEN - 1)) begin
            state_n   = ST_CRC;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 6'd1;
          end
        end
      end
      ST_CRC: begin
        // bit_cnt parks at CRC_LEN when a stuffed 0 is owed after the last bit
        if (stuff) begin
          tx_bit     = 1'b0;
          ones_cnt_n = '0;
          if (bit_cnt == 6'(CRC_LEN)) begin
            state_n   = ST_EOP;
            bit_cnt_n = '0;
          end
        end else begin
          tx_bit     = ~crc[4'd15 - bit_cnt[3:0]];
          ones_cnt_n = tx_bit ? ones_cnt + 3'd1 : 3'd0;
          if (bit_cnt == 6'(CRC_LEN - 1)) begin
            if (ones_cnt_n == STUFF_LIMIT) begin
              bit_cnt_n = 6'(CRC_LEN);
            end else begin
              state_n   = ST_EOP;
              bit_cnt_n = '0;
            end
          end else begin
            bit_cnt_n = bit_cnt + 6'd1;
          end
        end
      end
      ST_EOP: begin
        if (bit_cnt < 6'd2) begin
          tx_se0 = 1'b1;
          tx_bit = 1'b0;
        end else begin
          done = 1'b1;
        end
        if (bit_cnt == 6'(EOP_LEN - 1)) begin
          state_n   = ST_IDLE;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_send_data.sv
// Scoreboard bench for send_data: model builds each packet's bit stream.
// A negedge monitor pops expected cycles and checks CRC residual per packet.
module tb_send_data;

  typedef struct packed {
    logic b;
    logic se0;
    logic done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        send_start;
  logic        has_data;
  logic [3:0]  pid;
  logic [63:0] data;
  logic        tx_bit, tx_se0, tx_active, busy, done;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t pkt[$];
  bit   last_stuffed;
  logic act[$];

  send_data dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .send_start (send_start),
    .has_data   (has_data),
    .pid        (pid),
    .data       (data),
    .tx_bit     (tx_bit),
    .tx_se0     (tx_se0),
    .tx_active  (tx_active),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_step(logic [15:0] c, logic b);
    logic fb;
    fb = c[15] ^ b;
    c  = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h8005;
    return c;
  endfunction

  // Reference packet: raw fields, then zero insertion after six 1s.
  function automatic void build(logic [3:0] p, bit hd, logic [63:0] d);
    logic        raw[$];
    logic [15:0] c;
    int          run;
    c   = 16'hFFFF;
    run = 0;
    pkt.delete();
    last_stuffed = 0;
    for (int i = 0; i < 7; i++) pkt.push_back(3'b000);
    pkt.push_back(3'b100);
    for (int i = 0; i < 4; i++) pkt.push_back({p[i], 2'b00});
    for (int i = 0; i < 4; i++) pkt.push_back({~p[i], 2'b00});
    if (hd) begin
      for (int i = 0; i < 64; i++) begin
        raw.push_back(d[i]);
        c = crc_step(c, d[i]);
      end
      for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
      foreach (raw[i]) begin
        pkt.push_back({raw[i], 2'b00});
        last_stuffed = 0;
        run = raw[i] ? run + 1 : 0;
        if (run == 6) begin
          pkt.push_back(3'b000);
          run = 0;
          last_stuffed = 1;
        end
      end
    end
    pkt.push_back(3'b010);
    pkt.push_back(3'b010);
    pkt.push_back(3'b101);
  endfunction

  task automatic send(logic [3:0] p, bit hd, logic [63:0] d);
    send_start = 1'b1;
    pid        = p;
    has_data   = hd;
    data       = d;
    @(posedge clk);
    #1;
    send_start = 1'b0;
    pid        = 4'h0;
    has_data   = 1'b0;
    data       = 64'h0;
    build(p, hd, d);
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d cycles left, need 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Destuff DUT bits after SYNC+PID and run CRC over DATA+CRC.
  function automatic void check_residual();
    logic [15:0] c;
    int          run;
    c   = 16'hFFFF;
    run = 0;
    for (int i = 16; i < act.size(); i++) begin
      if (run == 6) begin
        run = 0;
      end else begin
        c   = crc_step(c, act[i]);
        run = act[i] ? run + 1 : 0;
      end
    end
    checks++;
    if (c !== 16'h800D) begin
      errors++;
      $display("FAIL crc_residual: got %h need 800d", c);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_L) begin
      act.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (tx_active !== 1'b1 || busy !== 1'b1 || tx_bit !== e.b ||
          tx_se0 !== e.se0 || done !== e.done) begin
        errors++;
        $display("FAIL stream: got act%b busy%b bit%b se0%b done%b need 1 1 %b %b %b",
                 tx_active, busy, tx_bit, tx_se0, done, e.b, e.se0, e.done);
      end
      if (!e.se0 && !e.done) act.push_back(tx_bit);
      if (e.done) begin
        if (act.size() > 16) check_residual();
        act.delete();
      end
    end else begin
      checks++;
      if (tx_active !== 1'b0 || busy !== 1'b0 || tx_bit !== 1'b1 ||
          tx_se0 !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle: got act%b busy%b bit%b se0%b done%b need 0 0 1 0 0",
                 tx_active, busy, tx_bit, tx_se0, done);
      end
    end
  end

  initial begin
    logic [63:0] d;
    bit          found;
    rst_L      = 1'b0;
    send_start = 1'b0;
    has_data   = 1'b0;
    pid        = 4'h0;
    data       = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(4'b0010, 1'b0, 64'h0);
    wait_idle();
    send(4'b0011, 1'b1, 64'h0);
    wait_idle();
    send(4'b1011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();

    found = 0;
    d     = 64'h0;
    for (int t = 0; t < 20000 && !found; t++) begin
      d = {$urandom(), $urandom()};
      build(4'b0011, 1'b1, d);
      found = last_stuffed;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stuff_end_search: got none need 1");
    end else begin
      send(4'b0011, 1'b1, d);
      wait_idle();
    end

    send(4'b1011, 1'b1, 64'h0123_4567_89AB_CDEF);
    repeat (40) @(posedge clk);
    #1;
    send_start = 1'b1;
    pid        = 4'b0101;
    has_data   = 1'b0;
    data       = 64'hDEAD_BEEF_0000_FFFF;
    @(posedge clk);
    #1;
    send_start = 1'b0;
    wait_idle();

    send(4'b0011, 1'b1, 64'h0);
    repeat (85) @(posedge clk);
    #1;
    rst_L = 1'b0;
    @(posedge clk);
    exp_q.delete();
    #1;
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    send(4'b1010, 1'b0, 64'h0);
    wait_idle();

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 2))
        0:       d = {$urandom(), $urandom()};
        1:       d = {$urandom(), $urandom()} | {$urandom(), $urandom()}
                   | {$urandom(), $urandom()};
        default: d = ~(64'h1 << $urandom_range(0, 63));
      endcase
      send(4'($urandom()), 1'($urandom_range(0, 1)), d);
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/send_data.md
# send_data

Transmit-side packet sequencer for the USB link: the counterpart of the receive data FSM. On a start pulse it latches a PID and an optional 64-bit payload, then serialises SYNC, PID, DATA, CRC16 and EOP one bit per clock as a pre-NRZI (NRZ) stream. It generates CRC16 internally and inserts stuffed zeros during DATA and CRC. It feeds the NRZI encoder / bus driver and reports completion to the host-side protocol controller.

## Interface
- No parameters. All field lengths are fixed constants in the shared package.
- clk  in  1  system clock, all logic on rising edge
- rst_L  in  1  synchronous, active-low reset
- send_start  in  1  one-cycle request, sampled only in IDLE
- has_data  in  1  1 = data packet (SYNC,PID,DATA,CRC,EOP); 0 = handshake/token-style (SYNC,PID,EOP); latched with send_start
- pid  in  4  packet ID, latched with send_start
- data  in  64  payload, latched with send_start, sent LSB first
- tx_bit  out  1  NRZ bit for current cycle (idle/J = 1)
- tx_se0  out  1  1 during the two SE0 cycles of EOP
- tx_active  out  1  1 from first SYNC bit through final EOP J cycle
- busy  out  1  1 in any state other than IDLE
- done  out  1  one-cycle pulse on the final EOP J cycle

## Operation
- States: IDLE, SYNC, PID, DATA, CRC, EOP. Moore outputs derived from state, counters and latched registers.
- IDLE: tx_bit=1, tx_se0=0, tx_active=0. On send_start=1, latch pid, data and has_data; clear bit_cnt; load CRC with 16'hFFFF; go to SYNC.
- SYNC: 8 cycles, bits 0,0,0,0,0,0,0,1 → PID.
- PID: 8 cycles, pid[0..3] then ~pid[0..3]. Then go to DATA if has_data, else EOP.
- DATA: 64 data bits, data[0] first. Each sent data bit (not stuffed bits) is shifted into the CRC16 (poly 16'h8005, x^16+x^15+x^2+1). Then → CRC.
- CRC: 16 cycles, ~crc[15] first down to ~crc[0]. The CRC register does not update in this state. Then → EOP.
- Bit stuffing, DATA and CRC only:
  - ones_cnt (3 bits) clears on entry to DATA, increments on each sent 1, clears on each sent 0 (stuffed or real), and carries across the DATA→CRC boundary.
  - After six consecutive 1s, the next cycle is a stuffed 0: tx_bit=0, bit_cnt and CRC hold, ones_cnt clears.
  - A stuffed 0 owed after the last CRC bit is sent before EOP.
- EOP: cycles 0–1 tx_se0=1, tx_bit=0; cycle 2 tx_se0=0, tx_bit=1, done=1 → IDLE.
- send_start while busy=1 is ignored. Latched fields are unaffected by input changes mid-packet.
- Width rules: bit_cnt is 6 bits and wraps 63→0 only at a field end. CRC arithmetic is modulo-2 on a 16-bit register.

## Timing
- Reset (rst_L=0 at an edge): state IDLE, tx_bit=1, tx_se0=0, tx_active=0, busy=0, done=0, ones_cnt=0, bit_cnt=0, CRC=16'hFFFF. Reset mid-packet aborts at that edge with no EOP emitted.
- Latency: send_start high at edge k → first SYNC bit (tx_active=1) in the cycle after edge k.
- Unstuffed lengths: handshake packet 19 cycles (8+8+3); data packet 99 cycles (8+8+64+16+3). Add one cycle per stuffed bit.
- done is high for exactly one cycle, with tx_active=1. The next cycle is IDLE, and a send_start in that IDLE cycle is accepted.

## Structure
- Package usb_tx_pkg: state enum, SYNC_PATTERN 8'b1000_0000 (LSB first), CRC16_POLY 16'h8005, CRC16_INIT 16'hFFFF, STUFF_LIMIT 3'd6, field lengths (8, 8, 64, 16, EOP 3).
- One sub-module: crc16_gen. Ports: clk, rst_L, clear, shift_en, bit_in, crc[15:0]. Serial LFSR.
- Sequencer, counters, stuffing logic and output mux live in send_data.

## Test plan
- ACK: pid=4'b0010, has_data=0 → tx_bit stream 0000000 1, 0100 1011, then SE0, SE0, J. done at cycle 19, busy low the cycle after.
- Zero payload: data=64'h0, pid=4'b0011 → 99 cycles, no stuffed bits. A bench CRC16 run over the 64 data bits plus the 16 transmitted CRC bits leaves residual 16'h800D.
- All-ones payload: data=64'hFFFF_FFFF_FFFF_FFFF → stuffed 0 after every six 1s (10 in DATA, ones_cnt=4 entering CRC). Unstuffed stream matches the reference; the CRC residual is again 16'h800D.
- Stuff at CRC end: choose data so the last CRC bit is the sixth consecutive 1 → one stuffed 0 precedes SE0; packet length 100+ cycles as computed by the model.
- Ignored restart: pulse send_start with different pid/data mid-DATA → transmitted packet unchanged, exactly one done.
- Reset mid-CRC: rst_L=0 for one cycle → next cycle tx_active=0, tx_bit=1, tx_se0=0, busy=0. A new send_start then produces a clean packet.
